// File: rtl/env_gen.sv
// Per-voice ADSR envelope generator: one IDLE->CALC->DONE pass advances the
// selected voice's stored envelope by a single sample step.
module env_gen #(
    parameter int NUM_VOICES = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       env_start_i,
    input  logic [1:0] voice_idx_i,
    input  logic       env_gate_i,
    input  logic [3:0] env_attack_i,
    input  logic [3:0] env_decay_i,
    input  logic [3:0] env_sustain_i,
    input  logic [3:0] env_release_i,
    output logic       env_ready_o,
    output logic [7:0] env_o,
    output logic [7:0] env3_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} fsm_t;
    typedef enum logic [1:0] {PH_ATTACK, PH_DECAY_SUSTAIN, PH_RELEASE} phase_t;

    fsm_t        state_reg, state_next;
    logic [1:0]  idx_reg;
    logic        gate_reg;
    logic [3:0]  attack_reg, decay_reg, sustain_reg, release_reg;
    logic [7:0]  env_o_reg;

    logic [7:0]  ctx_level [NUM_VOICES];
    phase_t      ctx_phase [NUM_VOICES];
    logic [11:0] ctx_cnt   [NUM_VOICES];
    logic        ctx_gate_q[NUM_VOICES];

    logic        idx_valid;
    logic [7:0]  cur_level, nxt_level, sustain_lvl;
    phase_t      cur_phase, edge_phase, nxt_phase;
    logic [11:0] cur_cnt, edge_cnt, nxt_cnt, period;
    logic        cur_gate_q;
    logic [12:0] cnt_inc;
    logic        step_en;

    function automatic logic [11:0] rate_period(input logic [3:0] sel);
        case (sel)
            4'd0:    rate_period = 12'd1;
            4'd1:    rate_period = 12'd2;
            4'd2:    rate_period = 12'd3;
            4'd3:    rate_period = 12'd4;
            4'd4:    rate_period = 12'd6;
            4'd5:    rate_period = 12'd9;
            4'd6:    rate_period = 12'd11;
            4'd7:    rate_period = 12'd13;
            4'd8:    rate_period = 12'd16;
            4'd9:    rate_period = 12'd39;
            4'd10:   rate_period = 12'd78;
            4'd11:   rate_period = 12'd125;
            4'd12:   rate_period = 12'd156;
            4'd13:   rate_period = 12'd469;
            4'd14:   rate_period = 12'd781;
            default: rate_period = 12'd1250;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            idx_reg     <= '0;
            gate_reg    <= 1'b0;
            attack_reg  <= '0;
            decay_reg   <= '0;
            sustain_reg <= '0;
            release_reg <= '0;
            env_o_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && env_start_i) begin
                idx_reg     <= voice_idx_i;
                gate_reg    <= env_gate_i;
                attack_reg  <= env_attack_i;
                decay_reg   <= env_decay_i;
                sustain_reg <= env_sustain_i;
                release_reg <= env_release_i;
            end
            if (state_reg == S_CALC) begin
                env_o_reg <= idx_valid ? nxt_level : 8'd0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (env_start_i) state_next = S_CALC;
            S_CALC:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Context read mux; an out-of-range index reads a harmless idle context.
    always_comb begin
        idx_valid  = int'(idx_reg) < NUM_VOICES;
        cur_level  = '0;
        cur_phase  = PH_RELEASE;
        cur_cnt    = '0;
        cur_gate_q = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (idx_reg == 2'(v)) begin
                cur_level  = ctx_level[v];
                cur_phase  = ctx_phase[v];
                cur_cnt    = ctx_cnt[v];
                cur_gate_q = ctx_gate_q[v];
            end
        end
    end

    always_comb begin
        edge_phase = cur_phase;
        edge_cnt   = cur_cnt;
        if (gate_reg && !cur_gate_q) begin
            edge_phase = PH_ATTACK;
            edge_cnt   = '0;
        end else if (!gate_reg && cur_gate_q) begin
            edge_phase = PH_RELEASE;
            edge_cnt   = '0;
        end

        case (edge_phase)
            PH_ATTACK:        period = rate_period(attack_reg);
            PH_DECAY_SUSTAIN: period = 12'd3 * rate_period(decay_reg);
            default:          period = 12'd3 * rate_period(release_reg);
        endcase

        // >= so that a period lowered below the running count fires immediately.
        cnt_inc = {1'b0, edge_cnt} + 13'd1;
        step_en = cnt_inc >= {1'b0, period};
        nxt_cnt = step_en ? 12'd0 : cnt_inc[11:0];

        sustain_lvl = {sustain_reg, sustain_reg};
        nxt_level   = cur_level;
        nxt_phase   = edge_phase;
        if (step_en) begin
            case (edge_phase)
                PH_ATTACK: begin
                    if (cur_level == 8'hFF) begin
                        nxt_phase = PH_DECAY_SUSTAIN;
                    end else begin
                        nxt_level = cur_level + 8'd1;
                        if (cur_level == 8'hFE) nxt_phase = PH_DECAY_SUSTAIN;
                    end
                end
                PH_DECAY_SUSTAIN: if (cur_level > sustain_lvl) nxt_level = cur_level - 8'd1;
                default:          if (cur_level != 8'd0) nxt_level = cur_level - 8'd1;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [7:0]  level_reg;
            phase_t      phase_reg;
            logic [11:0] rate_cnt_reg;
            logic        gate_q_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    level_reg    <= '0;
                    phase_reg    <= PH_RELEASE;
                    rate_cnt_reg <= '0;
                    gate_q_reg   <= 1'b0;
                end else if (state_reg == S_CALC && idx_reg == 2'(gi)) begin
                    level_reg    <= nxt_level;
                    phase_reg    <= nxt_phase;
                    rate_cnt_reg <= nxt_cnt;
                    gate_q_reg   <= gate_reg;
                end
            end

            assign ctx_level[gi]  = level_reg;
            assign ctx_phase[gi]  = phase_reg;
            assign ctx_cnt[gi]    = rate_cnt_reg;
            assign ctx_gate_q[gi] = gate_q_reg;
        end

        if (NUM_VOICES > 2) begin : g_readback
            assign env3_o = ctx_level[2];
        end else begin : g_no_readback
            assign env3_o = 8'd0;
        end
    endgenerate

    assign env_ready_o = (state_reg == S_DONE);
    assign env_o       = env_o_reg;

endmodule

// File: tb/tb_env_gen.sv
// Directed bench for env_gen: table-driven interleaved steps plus long
// attack/decay/release runs, busy-start and mid-operation reset sequences.
module tb_env_gen;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       env_start_i;
    logic [1:0] voice_idx_i;
    logic       env_gate_i;
    logic [3:0] env_attack_i, env_decay_i, env_sustain_i, env_release_i;
    logic       env_ready_o;
    logic [7:0] env_o, env3_o;

    int checks   = 0;
    int failures = 0;

    env_gen #(.NUM_VOICES(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .env_start_i(env_start_i),
        .voice_idx_i(voice_idx_i), .env_gate_i(env_gate_i),
        .env_attack_i(env_attack_i), .env_decay_i(env_decay_i),
        .env_sustain_i(env_sustain_i), .env_release_i(env_release_i),
        .env_ready_o(env_ready_o), .env_o(env_o), .env3_o(env3_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] idx;
        logic       gate;
        logic [3:0] a;
        logic [3:0] r;
        logic [7:0] exp_env;
        logic [7:0] exp_env3;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; env_start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One start pulse; checks ready timing T+1/T+2/T+3 and returns outputs at T+2.
    task automatic step(input logic [1:0] idx, input logic g, input logic [3:0] a,
                        input logic [3:0] d, input logic [3:0] s, input logic [3:0] r,
                        output logic [7:0] env, output logic [7:0] env3);
        @(negedge clk_i);
        voice_idx_i = idx; env_gate_i = g; env_attack_i = a;
        env_decay_i = d; env_sustain_i = s; env_release_i = r;
        env_start_i = 1'b1;
        @(posedge clk_i); #1;
        env_start_i = 1'b0;
        check("ready_t1", int'(env_ready_o), 0);
        @(posedge clk_i); #1;
        check("ready_t2", int'(env_ready_o), 1);
        env = env_o; env3 = env3_o;
        @(posedge clk_i); #1;
        check("ready_t3", int'(env_ready_o), 0);
        check("env_hold", int'(env_o), int'(env));
    endtask

    task automatic count_ready(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_i); #1;
            if (env_ready_o) pulses++;
        end
    endtask

    initial begin
        logic [7:0] e, e3;
        int pulses;

        rst_i = 1'b1; env_start_i = 1'b0; voice_idx_i = '0; env_gate_i = 1'b0;
        env_attack_i = '0; env_decay_i = '0; env_sustain_i = '0; env_release_i = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_env", int'(env_o), 0);
        check("rst_env3", int'(env3_o), 0);
        check("rst_ready", int'(env_ready_o), 0);

        // Gate low after reset: level 0, exactly one pulse
        step(2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, e, e3);
        check("gate_low_env", int'(e), 0);
        count_ready(6, pulses);
        check("gate_low_no_second", pulses, 0);

        // Interleaved voices, hand-computed
        do_reset();
        vecs[0]  = '{2'd0, 1'b1, 4'd0,  4'd0, 8'd1, 8'd0};
        vecs[1]  = '{2'd1, 1'b1, 4'd1,  4'd0, 8'd0, 8'd0};
        vecs[2]  = '{2'd2, 1'b1, 4'd2,  4'd0, 8'd0, 8'd0};
        vecs[3]  = '{2'd3, 1'b1, 4'd0,  4'd0, 8'd0, 8'd0};
        vecs[4]  = '{2'd0, 1'b1, 4'd0,  4'd0, 8'd2, 8'd0};
        vecs[5]  = '{2'd1, 1'b1, 4'd1,  4'd0, 8'd1, 8'd0};
        vecs[6]  = '{2'd2, 1'b1, 4'd2,  4'd0, 8'd0, 8'd0};
        vecs[7]  = '{2'd2, 1'b1, 4'd2,  4'd0, 8'd1, 8'd1};
        vecs[8]  = '{2'd0, 1'b1, 4'd0,  4'd0, 8'd3, 8'd1};
        vecs[9]  = '{2'd1, 1'b1, 4'd1,  4'd0, 8'd1, 8'd1};
        vecs[10] = '{2'd3, 1'b0, 4'd0,  4'd0, 8'd0, 8'd1};
        vecs[11] = '{2'd1, 1'b1, 4'd1,  4'd0, 8'd2, 8'd1};
        vecs[12] = '{2'd2, 1'b1, 4'd2,  4'd0, 8'd1, 8'd1};
        vecs[13] = '{2'd0, 1'b0, 4'd0,  4'd0, 8'd3, 8'd1};
        vecs[14] = '{2'd0, 1'b0, 4'd0,  4'd0, 8'd3, 8'd1};
        vecs[15] = '{2'd0, 1'b0, 4'd0,  4'd0, 8'd2, 8'd1};
        vecs[16] = '{2'd2, 1'b1, 4'd2,  4'd0, 8'd1, 8'd1};
        vecs[17] = '{2'd2, 1'b1, 4'd2,  4'd0, 8'd2, 8'd2};
        vecs[18] = '{2'd1, 1'b1, 4'd15, 4'd0, 8'd2, 8'd2};
        vecs[19] = '{2'd1, 1'b1, 4'd0,  4'd0, 8'd3, 8'd2};
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].idx, vecs[i].gate, vecs[i].a, 4'd0, 4'd0, vecs[i].r, e, e3);
            check($sformatf("vec%0d_env", i), int'(e), int'(vecs[i].exp_env));
            check($sformatf("vec%0d_env3", i), int'(e3), int'(vecs[i].exp_env3));
        end

        // Attack A=0 to 255, decay D=0 to sustain 136, hold
        do_reset();
        for (int k = 1; k <= 255; k++) begin
            step(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0, e, e3);
            check("attack_env", int'(e), k);
        end
        for (int j = 1; j <= 357; j++) begin
            step(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0, e, e3);
            check("decay_env", int'(e), 255 - j / 3);
        end
        for (int j = 0; j < 12; j++) begin
            step(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0, e, e3);
            check("sustain_hold", int'(e), 136);
        end
        for (int j = 0; j < 6; j++) begin
            step(2'd0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd0, e, e3);
            check("sustain_raised", int'(e), 136);
        end
        check("env3_untouched", int'(env3_o), 0);

        // Release R=0 from 136 to 0, then hold at 0
        for (int j = 1; j <= 408; j++) begin
            step(2'd0, 1'b0, 4'd0, 4'd0, 4'd8, 4'd0, e, e3);
            check("release_env", int'(e), 136 - j / 3);
        end
        for (int j = 0; j < 5; j++) begin
            step(2'd0, 1'b0, 4'd0, 4'd0, 4'd8, 4'd0, e, e3);
            check("release_floor", int'(e), 0);
        end

        // Re-gate at level 50 continues from 51
        for (int k = 1; k <= 50; k++) begin
            step(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0, e, e3);
        end
        check("pre_regate", int'(e), 50);
        step(2'd0, 1'b0, 4'd0, 4'd0, 4'd8, 4'd15, e, e3);
        check("release_slow", int'(e), 50);
        step(2'd0, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0, e, e3);
        check("regate_env", int'(e), 51);

        // Attack rate 1: k/2
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(2'd1, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0, e, e3);
            check("attack_rate1", int'(e), k / 2);
        end

        // Start held high for 3 cycles: one step, one pulse
        do_reset();
        @(negedge clk_i);
        voice_idx_i = 2'd0; env_gate_i = 1'b1; env_attack_i = 4'd0;
        env_start_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        env_start_i = 1'b0;
        check("busy_env", int'(env_o), 1);
        count_ready(6, pulses);
        check("busy_pulses", pulses, 0);
        step(2'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, e, e3);
        check("busy_one_step", int'(e), 2);

        // Reset in CALC discards writeback and suppresses ready
        for (int k = 0; k < 4; k++) step(2'd2, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, e, e3);
        check("pre_rst_env3", int'(e3), 4);
        @(negedge clk_i);
        voice_idx_i = 2'd2; env_gate_i = 1'b1; env_start_i = 1'b1;
        @(negedge clk_i);
        env_start_i = 1'b0; rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_calc_ready", int'(env_ready_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        count_ready(5, pulses);
        check("rst_calc_pulses", pulses, 0);
        check("rst_calc_env", int'(env_o), 0);
        check("rst_calc_env3", int'(env3_o), 0);
        step(2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, e, e3);
        check("rst_v0_level", int'(e), 0);
        step(2'd2, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, e, e3);
        check("rst_v2_level", int'(e), 0);

        // Reset has priority over a simultaneous start
        @(negedge clk_i);
        rst_i = 1'b1; env_start_i = 1'b1; voice_idx_i = 2'd0; env_gate_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; env_start_i = 1'b0;
        count_ready(5, pulses);
        check("rst_start_pulses", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
